// File: rtl/shield_scheduler_pkg.sv
// shield_pkg: FSM states, slot table and counter width shared by the shield scheduler.
package shield_pkg;
   typedef enum logic [1:0] {IDLE, COOLDOWN, VISIBLE, ACTIVE} shield_state_t;
   typedef logic [1:0] slot_t;
   localparam int CNT_W = 16;
   localparam logic [10:0] SLOT_X [4] = '{11'd300, 11'd700, 11'd150, 11'd900};
   localparam logic [10:0] SLOT_Y [4] = '{11'd200, 11'd450, 11'd600, 11'd150};
endpackage

// File: rtl/shield_scheduler_frame_counter.sv
// frame_counter: loadable frame down-counter; done pulses on a tick while the count is 1.
module frame_counter
   import shield_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done,
   output logic [W-1:0] cnt_d
);
   logic [W-1:0] cnt_q;
   always_comb begin
      done  = tick && cnt_q == W'(1);
      cnt_d = load ? load_val : (tick && cnt_q > W'(1)) ? cnt_q - W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/shield_scheduler.sv
// shield_scheduler: respawn delay, pickup spawn, shield grant and loss per game round.
// Define SHIELD_TIMEOUT_EN to expire the shield after SHIELD_FRAMES frames.
module shield_scheduler
   import shield_pkg::*;
#(
   parameter int OFFSET         = 64,
   parameter int RESPAWN_FRAMES = 180,
   parameter int SHIELD_FRAMES  = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_game,
   input  logic        frame_tick,
   input  logic [9:0]  hit,
   input  logic [10:0] xpos_donkey,
   input  logic [10:0] ypos_donkey,
   output logic        shield_visible,
   output logic [10:0] xpos_shield,
   output logic [10:0] ypos_shield,
   output logic        is_shielded,
   output logic [7:0]  shield_frames_left
);
   shield_state_t state_q, state_d;
   slot_t slot_q, slot_d;
   logic load, tick_en, done, in_box;
   logic [CNT_W-1:0] load_val, cnt_d;
   logic vis_q, vis_d, shd_q, shd_d;
   logic [10:0] xs_q, xs_d, ys_q, ys_d;

   frame_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .tick(tick_en), .load(load),
      .load_val(load_val), .done(done), .cnt_d(cnt_d)
   );

   // 12-bit compare so slot origin + OFFSET cannot wrap
   assign in_box = {1'b0, SLOT_X[slot_q]} <= {1'b0, xpos_donkey}
                && {1'b0, xpos_donkey} < {1'b0, SLOT_X[slot_q]} + 12'(OFFSET)
                && {1'b0, SLOT_Y[slot_q]} <= {1'b0, ypos_donkey}
                && {1'b0, ypos_donkey} < {1'b0, SLOT_Y[slot_q]} + 12'(OFFSET);

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      load     = 1'b0;
      load_val = '0;
      tick_en  = 1'b0;
      if (!start_game) begin
         state_d = IDLE;
         slot_d  = '0;
         load    = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d  = COOLDOWN;
               load     = 1'b1;
               load_val = CNT_W'(RESPAWN_FRAMES);
            end
            COOLDOWN: begin
               tick_en = frame_tick;
               if (done) state_d = VISIBLE;
            end
            VISIBLE: begin
               if (in_box) begin
                  state_d  = ACTIVE;
                  slot_d   = slot_q + 2'd1;
                  load     = 1'b1;
                  load_val = CNT_W'(SHIELD_FRAMES);
               end
            end
            ACTIVE: begin
`ifdef SHIELD_TIMEOUT_EN
               tick_en = frame_tick;
`endif
               if (|hit || done) begin
                  state_d  = COOLDOWN;
                  load     = 1'b1;
                  load_val = CNT_W'(RESPAWN_FRAMES);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      vis_d = state_d == VISIBLE;
      shd_d = state_d == ACTIVE;
      xs_d  = state_d == IDLE ? 11'd0 : SLOT_X[slot_d];
      ys_d  = state_d == IDLE ? 11'd0 : SLOT_Y[slot_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         slot_q  <= '0;
         vis_q   <= 1'b0;
         shd_q   <= 1'b0;
         xs_q    <= '0;
         ys_q    <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         vis_q   <= vis_d;
         shd_q   <= shd_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
      end
   end

`ifdef SHIELD_TIMEOUT_EN
   logic [7:0] left_q, left_d;
   assign left_d = !shd_d ? 8'd0 : (cnt_d > CNT_W'(255)) ? 8'd255 : cnt_d[7:0];
   always_ff @(posedge clk) begin
      if (rst) left_q <= '0;
      else     left_q <= left_d;
   end
   assign shield_frames_left = left_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt_d;
   assign shield_frames_left = 8'd0;
`endif

   assign shield_visible = vis_q;
   assign is_shielded    = shd_q;
   assign xpos_shield    = xs_q;
   assign ypos_shield    = ys_q;
endmodule
